// File: rtl/mmio_write_queue.sv
// Memory-mapped write queue: processor stores to PUSH_ADR are buffered in a
// first-word-fall-through FIFO that a peripheral drains with a valid/ready handshake.
module mmio_write_queue #(
    parameter int          DEPTH    = 8,
    parameter logic [31:0] PUSH_ADR = 32'h100,
    parameter logic [31:0] STAT_ADR = 32'h104
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic [31:0] PerData,
    output logic        PerValid,
    input  logic        PerReady,
    output logic [3:0]  Count,
    output logic        Full,
    output logic        Overflow
);

    localparam int PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0]     mem [DEPTH];
    logic [PtrW-1:0] rdPtr;
    logic [PtrW-1:0] wrPtr;
    logic            pushReq;
    logic            popFire;
    logic            pushAccept;
    logic            dropEvt;
    logic            clrReq;

    assign pushReq    = MemWrite && (DataAdr == PUSH_ADR);
    assign clrReq     = MemWrite && (DataAdr == STAT_ADR) && WriteData[0];
    assign PerValid   = (Count != 4'd0);
    assign Full       = (Count == 4'(DEPTH));
    assign popFire    = PerValid && PerReady;
    // A full queue still accepts a push when the head leaves on the same edge.
    assign pushAccept = pushReq && (!Full || popFire);
    assign dropEvt    = pushReq && Full && !popFire;
    assign PerData    = mem[rdPtr];

    // Storage is intentionally left out of reset; pointers and Count define validity.
    always_ff @(posedge Clk) begin
        if (pushAccept && !Reset) begin
            mem[wrPtr] <= WriteData;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            rdPtr    <= '0;
            wrPtr    <= '0;
            Count    <= 4'd0;
            Overflow <= 1'b0;
        end else begin
            if (pushAccept) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (popFire) begin
                rdPtr <= rdPtr + 1'b1;
            end
            if (pushAccept && !popFire) begin
                Count <= Count + 4'd1;
            end else if (popFire && !pushAccept) begin
                Count <= Count - 4'd1;
            end
            // A new drop wins over a clear issued in the same cycle.
            if (dropEvt) begin
                Overflow <= 1'b1;
            end else if (clrReq) begin
                Overflow <= 1'b0;
            end
        end
    end

    always_comb begin
        ReadData = 32'd0;
        if (DataAdr == STAT_ADR) begin
            ReadData = {25'd0, Overflow, Full, !PerValid, Count};
        end else if (DataAdr == PUSH_ADR) begin
            ReadData = PerValid ? PerData : 32'd0;
        end
    end

endmodule

// File: doc/mmio_write_queue.md
MMIO_WRITE_QUEUE -- requirements
Module: mmio_write_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, the number of FIFO entries (power of two).
REQ-002 The block SHALL have parameter PUSH_ADR, default 32'h100, the word address that enqueues on write.
REQ-003 The block SHALL have parameter STAT_ADR, default 32'h104, the status/control word address.
REQ-004 Port Clk, input, 1, the single clock; all state updates on rising edge.
REQ-005 Port Reset, input, 1, synchronous active-high reset.
REQ-006 Port MemWrite, input, 1, processor data-bus write strobe.
REQ-007 Port DataAdr, input, 32, processor data-bus address.
REQ-008 Port WriteData, input, 32, processor data-bus write data.
REQ-009 Port ReadData, output, 32, combinational read-back for the processor.
REQ-010 Port PerData, output, 32, head-of-queue word to the peripheral.
REQ-011 Port PerValid, output, 1, head word valid.
REQ-012 Port PerReady, input, 1, peripheral accepts the head word.
REQ-013 Port Count, output, 4, current occupancy, 0..DEPTH.
REQ-014 Port Full, output, 1, Count equals DEPTH.
REQ-015 Port Overflow, output, 1, sticky dropped-write flag.

Function
REQ-016 Push request SHALL be MemWrite=1 and DataAdr==PUSH_ADR; no other address enqueues.
REQ-017 Pop SHALL occur on a rising edge where PerValid=1 and PerReady=1.
REQ-018 Queue SHALL be first-word-fall-through: PerValid = (Count!=0), PerData = entry at read pointer, no added latency.
REQ-019 A pushed word SHALL appear on PerData with PerValid=1 in the cycle after the push edge when the queue was empty.
REQ-020 Read and write pointers SHALL be log2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-021 Push while not full: store WriteData at write pointer, advance write pointer, Count+1.
REQ-022 Push while full with simultaneous pop: push SHALL be accepted, Count unchanged, both pointers advance.
REQ-023 Push while full without pop: word SHALL be dropped, pointers/Count unchanged, Overflow set to 1.
REQ-024 Simultaneous push and pop when not full and not empty: Count unchanged, both pointers advance.
REQ-025 PerReady while empty SHALL have no effect; Count never goes below 0.
REQ-026 Overflow SHALL stay 1 until Reset or a write to STAT_ADR with WriteData[0]=1; clear and a new overflow event in the same cycle SHALL leave Overflow=1.
REQ-027 Writes to STAT_ADR SHALL not enqueue and SHALL affect only Overflow.
REQ-028 ReadData at DataAdr==STAT_ADR SHALL be {25'b0, Overflow, Full, Empty, Count[3:0]} with Empty=(Count==0).
REQ-029 ReadData at DataAdr==PUSH_ADR SHALL be PerData when PerValid=1, else 0; all other addresses SHALL return 0.
REQ-030 Full SHALL be registered-state derived (Count==DEPTH), never from same-cycle inputs.

Reset
REQ-031 On Reset=1 at a rising edge: pointers=0, Count=0, Overflow=0; thus PerValid=0, Full=0.
REQ-032 Reset SHALL take priority over push, pop and Overflow clear in the same cycle.
REQ-033 Reset mid-operation SHALL discard all queued words; storage array contents need not be cleared.
REQ-034 Outputs before the first reset edge are undefined; bench holds Reset high at least two edges.

Verification
REQ-035 Reset, then write 7 to 0x100 -> next cycle PerValid=1, PerData=7, Count=1, ReadData@0x104=32'h1.
REQ-036 PerReady=0, nine writes of 1..9 to 0x100 -> Count=8, Full=1, Overflow=1, drain with PerReady=1 yields 1..8 in order, then PerValid=0.
REQ-037 Queue full (1..8), PerReady=1 and write 9 same cycle -> Count stays 8, Overflow stays 0, drain order 2..9.
REQ-038 Overflow=1, write 32'h1 to 0x104 -> Overflow=0 next cycle, Count unchanged; write 32'h0 to 0x104 -> Overflow unchanged.
REQ-039 Fill 5 entries, assert Reset for one edge with a concurrent push -> Count=0, PerValid=0, ReadData@0x100=0.
REQ-040 Continuous push with PerReady=1 for 20 cycles, values 0..19 -> pointer wrap exercised, Count stays 1 after first cycle, PerData sequence 0..19 with no loss.
